// File: rtl/comp_arbiter_pkg.sv
// Shared definitions for the two-requester complement/abs arbiter.
// This holds the width default, the mode and state encodings, and the requester count.
package comp_arbiter_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int NUM_REQ   = 2;

  typedef enum logic {
    MODE_NEG = 1'b0,
    MODE_ABS = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/comp_arbiter_if.sv
// Request/response bundle between the two requesters, the arbiter and the result consumer.
interface comp_arbiter_if
  import comp_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic             req0_mode;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic             req1_mode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_id;
  logic             rsp_ovf;

  modport master (
    output req0_valid, req0_a, req0_mode, req1_valid, req1_a, req1_mode, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_mode, req1_valid, req1_a, req1_mode, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_ovf
  );
endinterface

// File: rtl/comp_arbiter_complementor.sv
// Two's complement datapath that is shared by both requesters.
module complementor #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] compA
);
  assign compA = ~A + WIDTH'(1);
endmodule

// File: rtl/comp_arbiter.sv
// Round-robin arbiter with two requesters that feeds a single complementor.
// The result sits in a one-entry output register that a two-state FSM tracks.
module comp_arbiter
  import comp_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  comp_arbiter_if.slave  bus
);
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             id;
    logic             ovf;
  } rsp_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e                          state;
  rsp_t                            rspQ, rspD;
  logic                            lastGnt;
  logic [NUM_REQ-1:0]              reqValid, reqReady, reqMode;
  logic [NUM_REQ-1:0][WIDTH-1:0]   reqA;
  logic                            canAccept, gnt, accept;
  logic [WIDTH-1:0]                opA, negA;
  mode_e                           opMode;

  assign reqValid = {bus.req1_valid, bus.req0_valid};
  assign reqMode  = {bus.req1_mode, bus.req0_mode};
  assign reqA     = {bus.req1_a, bus.req0_a};

  // rst_n gates the handshake so that nothing is offered while the async reset is held.
  assign canAccept = rst_n && ((state == ST_EMPTY) || bus.rsp_ready);
  assign gnt       = (&reqValid) ? ~lastGnt : reqValid[1];
  assign accept    = canAccept && (|reqValid);
  assign reqReady  = {accept && gnt, accept && !gnt};

  assign bus.req0_ready = reqReady[0];
  assign bus.req1_ready = reqReady[1];

  assign opA    = reqA[gnt];
  assign opMode = mode_e'(reqMode[gnt]);

  complementor #(.WIDTH(WIDTH)) u_comp (
    .A     (opA),
    .compA (negA)
  );

  always_comb begin
    rspD.id   = gnt;
    rspD.ovf  = (opA == MIN_NEG);
    rspD.data = (opMode == MODE_ABS && !opA[WIDTH-1]) ? opA : negA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      rspQ    <= '0;
      lastGnt <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state   <= ST_FULL;
            rspQ    <= rspD;
            lastGnt <= gnt;
          end
        end
        ST_FULL: begin
          if (bus.rsp_ready) begin
            if (accept) begin
              rspQ    <= rspD;
              lastGnt <= gnt;
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  assign bus.rsp_valid = (state == ST_FULL);
  assign bus.rsp_data  = rspQ.data;
  assign bus.rsp_id    = rspQ.id;
  assign bus.rsp_ovf   = rspQ.ovf;
endmodule

// File: tb/tb_comp_arbiter.sv
// Scoreboard bench for comp_arbiter: it runs directed corner cases first, then random traffic.
module tb_comp_arbiter;
  import comp_arbiter_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic         id;
    logic         ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  comp_arbiter_if #(.WIDTH(W)) bus ();

  comp_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  logic lastGnt = 1'b1;
  logic fullNow = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: the result is written as 2^W - a, with ABS passing non-negative values through.
  function automatic exp_t model(input logic [W-1:0] a, input logic mode, input logic id);
    longint unsigned span, av;
    exp_t e;
    span  = 64'd1 << W;
    av    = 64'(a);
    e.id  = id;
    e.ovf = (av == span / 2);
    if (mode && av < span / 2) e.data = a;
    else                       e.data = W'((span - av) % span);
    return e;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic m0,
                       input logic v1, input logic [W-1:0] a1, input logic m1,
                       input logic rr);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_mode = m0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_mode = m1;
    bus.rsp_ready  = rr;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // Response monitor: it checks the held result and pops the entry when the consumer takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        fullNow = (sb.size() != 0);
        chk("rsp_valid", W'(bus.rsp_valid), W'(fullNow));
        if (fullNow) begin
          e = sb[0];
          chk("rsp_data", bus.rsp_data, e.data);
          chk("rsp_id", W'(bus.rsp_id), W'(e.id));
          chk("rsp_ovf", W'(bus.rsp_ovf), W'(e.ovf));
          if (bus.rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Accept monitor: it predicts the grant, checks the readies and pushes the expected result.
  initial begin
    logic canAcc, win, v0, v1;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        v0     = bus.req0_valid;
        v1     = bus.req1_valid;
        canAcc = !fullNow || bus.rsp_ready;
        win    = (v0 && v1) ? !lastGnt : v1;
        chk("req0_ready", W'(bus.req0_ready), W'(canAcc && (v0 || v1) && !win));
        chk("req1_ready", W'(bus.req1_ready), W'(canAcc && (v0 || v1) && win));
        if (canAcc && (v0 || v1)) begin
          lastGnt = win;
          if (win) sb.push_back(model(bus.req1_a, bus.req1_mode, 1'b1));
          else     sb.push_back(model(bus.req0_a, bus.req0_mode, 1'b0));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    drive(1'b1, 32'h1234, 1'b0, 1'b1, 32'h5678, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    #3;
    chk("reset rsp_valid", W'(bus.rsp_valid), '0);
    chk("reset req0_ready", W'(bus.req0_ready), '0);
    chk("reset req1_ready", W'(bus.req1_ready), '0);
    chk("reset rsp_data", bus.rsp_data, '0);
    chk("reset rsp_id", W'(bus.rsp_id), '0);
    chk("reset rsp_ovf", W'(bus.rsp_ovf), '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Single negate request
    @(negedge clk); drive(1'b1, 32'h5, MODE_NEG, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk); idle(); #3;
    chk("single data", bus.rsp_data, 32'hFFFF_FFFB);
    chk("single id", W'(bus.rsp_id), '0);
    chk("single ovf", W'(bus.rsp_ovf), '0);

    // Negate of zero, then abs on requester 1, including the most-negative value
    @(negedge clk); drive(1'b1, '0, MODE_NEG, 1'b0, '0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, 32'hFFFF_FF9C, MODE_ABS, 1'b1); #3;
    chk("neg0 data", bus.rsp_data, '0);
    chk("neg0 ovf", W'(bus.rsp_ovf), '0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, 32'h8000_0000, MODE_ABS, 1'b1); #3;
    chk("abs data", bus.rsp_data, 32'h0000_0064);
    chk("abs id", W'(bus.rsp_id), W'(1));
    chk("abs ovf", W'(bus.rsp_ovf), '0);
    @(negedge clk); idle(); #3;
    chk("absmin data", bus.rsp_data, 32'h8000_0000);
    chk("absmin ovf", W'(bus.rsp_ovf), W'(1));

    // Contention: the grant alternates starting with requester 0, one result per cycle
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(1'b1, W'(k), MODE_NEG, 1'b1, W'(100 + k), MODE_NEG, 1'b1);
      if (k > 0) begin
        #3;
        chk("contend id", W'(bus.rsp_id), W'((k - 1) % 2));
        chk("contend valid", W'(bus.rsp_valid), W'(1));
      end
    end

    // Backpressure: while FULL and stalled nothing is accepted and the result holds
    @(negedge clk); drive(1'b1, 32'h7, MODE_NEG, 1'b0, '0, 1'b0, 1'b1); #3;
    chk("contend last id", W'(bus.rsp_id), W'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1'b1, 32'h11, MODE_NEG, 1'b1, 32'h22, MODE_NEG, 1'b0); #3;
      chk("stall req0_ready", W'(bus.req0_ready), '0);
      chk("stall req1_ready", W'(bus.req1_ready), '0);
      chk("stall hold data", bus.rsp_data, 32'hFFFF_FFF9);
    end
    @(negedge clk); drive(1'b1, 32'h11, MODE_NEG, 1'b1, 32'h22, MODE_NEG, 1'b1); #3;
    chk("release req1_ready", W'(bus.req1_ready), W'(1));
    chk("release req0_ready", W'(bus.req0_ready), '0);
    @(negedge clk); idle(); #3;
    chk("release data", bus.rsp_data, 32'hFFFF_FFDE);

    // Reset mid-operation while FULL
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, 32'h3, MODE_ABS, 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0); #3;
    chk("prereset valid", W'(bus.rsp_valid), W'(1));
    rst_n = 1'b0;
    drive(1'b1, 32'h9, MODE_NEG, 1'b1, 32'hA, MODE_NEG, 1'b1);
    #1;
    chk("async rsp_valid", W'(bus.rsp_valid), '0);
    chk("inreset req0_ready", W'(bus.req0_ready), '0);
    chk("inreset req1_ready", W'(bus.req1_ready), '0);
    sb.delete();
    lastGnt = 1'b1;
    fullNow = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("postreset req0_ready", W'(bus.req0_ready), W'(1));
    chk("postreset req1_ready", W'(bus.req1_ready), '0);

    // Random traffic against the scoreboard
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 99) < 60), pickOperand(), 1'($urandom),
            1'($urandom_range(0, 99) < 60), pickOperand(), 1'($urandom),
            1'($urandom_range(0, 99) < 70));
    end
    @(negedge clk); idle();
    repeat (4) @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/comp_arbiter.md
COMP_ARBITER -- requirements
Module: comp_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester 0 (ALU) / requester 1 (branch unit) operand valid.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operand accepted this cycle when valid and ready are both 1.
REQ-006 SHALL have ports req0_a / req1_a  input  WIDTH  operand.
REQ-007 SHALL have ports req0_mode / req1_mode  input  1  0 = negate (two's complement), 1 = absolute value.
REQ-008 SHALL have port rsp_valid  output  1  result held in output register.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes result when rsp_valid and rsp_ready are both 1.
REQ-010 SHALL have port rsp_data  output  WIDTH  result.
REQ-011 SHALL have port rsp_id  output  1  requester index that owns rsp_data.
REQ-012 SHALL have port rsp_ovf  output  1  result not representable (operand = most-negative value).

Function
REQ-013 SHALL implement a two-state FSM: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-014 SHALL be able to accept a request when state is EMPTY, or when state is FULL and rsp_ready=1 in the same cycle (pass-through, zero bubble).
REQ-015 SHALL grant at most one requester per cycle; req<i>_ready=1 only for the granted requester and only while it can accept.
REQ-016 SHALL arbitrate round-robin: if both are valid, the grant goes to the requester not granted last; if one is valid, it wins regardless of history.
REQ-017 SHALL update the last-granted pointer only on an actual accept (valid and ready).
REQ-018 SHALL make req<i>_ready a function of current state, rsp_ready, the valids and the pointer only, never of req<i>_a or req<i>_mode.
REQ-019 SHALL register the result: accept in cycle N gives rsp_valid=1 with the result in cycle N+1, a latency of 1.
REQ-020 SHALL compute mode 0 as (~a + 1) mod 2^WIDTH and mode 1 as a when a[WIDTH-1]=0, otherwise (~a + 1).
REQ-021 SHALL set rsp_ovf=1 exactly when a = 1 followed by WIDTH-1 zeros, in either mode, with rsp_data = the same value.
REQ-022 SHALL produce negate of 0 = 0 with rsp_ovf=0.
REQ-023 SHALL hold rsp_data, rsp_id and rsp_ovf stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL go FULL->EMPTY on rsp_ready=1 with no new accept, and stay FULL with new contents on rsp_ready=1 plus a new accept.
REQ-025 SHALL ignore rsp_ready while EMPTY.
REQ-026 SHALL leave rsp_data, rsp_id and rsp_ovf unchanged when returning to EMPTY.

Reset
REQ-027 SHALL, while rst_n=0, force state EMPTY, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_ovf=0, and set the last-granted pointer to 1 so requester 0 wins the first contention.
REQ-028 SHALL discard any held result on reset mid-operation, and SHALL hold req0_ready=req1_ready=0 during reset.
REQ-029 SHALL resume normal operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-030 SHALL take WIDTH default, mode encodings (NEG=0, ABS=1) and FSM state encodings from the shared KGP_RISC definitions include file.
REQ-031 SHALL instantiate exactly one existing Complementor sub-module (A -> compA) as the shared datapath, with no second negation path.
REQ-032 SHALL feed the operand mux (from the grant) into that Complementor; the ABS select and overflow detect are local logic.

Verification
REQ-033 Single request: req0 negate a=0x00000005 -> next cycle rsp_valid=1, rsp_data=0xFFFFFFFB, rsp_id=0, rsp_ovf=0.
REQ-034 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; one result per cycle with no bubble.
REQ-035 Backpressure: rsp_ready=0 for 3 cycles while FULL -> both ready=0; rsp_data is held; on release the next request is accepted the same cycle.
REQ-036 Abs and overflow: req1 abs 0xFFFFFF9C -> 0x00000064, ovf=0; req1 abs 0x80000000 -> 0x80000000, ovf=1; req0 negate 0 -> 0, ovf=0.
REQ-037 Reset mid-operation: rst_n low while FULL -> rsp_valid=0 immediately (asynchronous); after release, contention grants requester 0 first.
